// File: rtl/cache_line_write_ctrl.sv
// Write-port controller for the byte-cell cache data array: arbitrates CPU byte
// stores against an in-order byte-serial line refill and registers one write per cycle.
module cache_line_write_ctrl #(
    parameter int  LINE_BYTES = 4,
    parameter int  SETS       = 8,
    localparam int SET_W      = $clog2(SETS),
    localparam int OFF_W      = $clog2(LINE_BYTES)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_st_req,
    input  logic [SET_W-1:0]      i_st_set,
    input  logic [OFF_W-1:0]      i_st_byte,
    input  logic [7:0]            i_st_data,
    output logic                  o_st_ack,
    input  logic                  i_fill_start,
    input  logic [SET_W-1:0]      i_fill_set,
    input  logic                  i_fill_valid,
    input  logic [7:0]            i_fill_data,
    output logic                  o_fill_ready,
    output logic                  o_fill_done,
    output logic                  o_busy,
    output logic                  o_arr_we,
    output logic [SET_W-1:0]      o_arr_set,
    output logic [LINE_BYTES-1:0] o_arr_byte_en,
    output logic [7:0]            o_arr_data
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [SET_W-1:0]      r_lock_set;
    logic [OFF_W-1:0]      r_cnt;
    logic                  r_arr_we;
    logic [SET_W-1:0]      r_arr_set;
    logic [LINE_BYTES-1:0] r_arr_byte_en;
    logic [7:0]            r_arr_data;

    logic                  w_fill_xfer;
    logic                  w_lock_hit;
    logic                  w_last_byte;
    logic                  w_st_ack;

    // A store collides with the line being refilled, or with the line about to be.
    assign w_fill_xfer = i_fill_valid && (r_state == S_FILL);
    assign w_lock_hit  = ((r_state == S_FILL) && (i_st_set == r_lock_set)) ||
                         ((r_state == S_IDLE) && i_fill_start && (i_st_set == i_fill_set));
    assign w_last_byte = (r_cnt == OFF_W'(LINE_BYTES - 1));
    assign w_st_ack    = !i_reset && i_st_req && !w_fill_xfer && !w_lock_hit;
    assign o_st_ack    = w_st_ack;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (i_fill_start) w_next_state = S_FILL;
            S_FILL:  if (w_fill_xfer && w_last_byte) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_fill_ready = (r_state == S_FILL);
        o_fill_done  = (r_state == S_DONE);
        o_busy       = (r_state != S_IDLE);
    end

    // The counter holds at the last byte; only a new fill_start rewinds it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lock_set <= '0;
            r_cnt      <= '0;
        end else if ((r_state == S_IDLE) && i_fill_start) begin
            r_lock_set <= i_fill_set;
            r_cnt      <= '0;
        end else if (w_fill_xfer && !w_last_byte) begin
            r_cnt <= r_cnt + OFF_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_arr_we      <= 1'b0;
            r_arr_set     <= '0;
            r_arr_byte_en <= '0;
            r_arr_data    <= '0;
        end else if (w_fill_xfer) begin
            r_arr_we      <= 1'b1;
            r_arr_set     <= r_lock_set;
            r_arr_byte_en <= LINE_BYTES'(1) << r_cnt;
            r_arr_data    <= i_fill_data;
        end else if (w_st_ack) begin
            r_arr_we      <= 1'b1;
            r_arr_set     <= i_st_set;
            r_arr_byte_en <= LINE_BYTES'(1) << i_st_byte;
            r_arr_data    <= i_st_data;
        end else begin
            r_arr_we      <= 1'b0;
            r_arr_byte_en <= '0;
        end
    end

    assign o_arr_we      = r_arr_we;
    assign o_arr_set     = r_arr_set;
    assign o_arr_byte_en = r_arr_byte_en;
    assign o_arr_data    = r_arr_data;

endmodule

// File: tb/tb_cache_line_write_ctrl.sv
// Self-checking bench for cache_line_write_ctrl: a transaction-level model checked
// every cycle, plus directed scenarios pinned by hand-computed literals.
module tb_cache_line_write_ctrl;

    localparam int LINE_BYTES = 4;
    localparam int SETS       = 8;
    localparam int SET_W      = $clog2(SETS);
    localparam int OFF_W      = $clog2(LINE_BYTES);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  stReq;
    logic [SET_W-1:0]      stSet;
    logic [OFF_W-1:0]      stByte;
    logic [7:0]            stData;
    logic                  stAck;
    logic                  fillStart;
    logic [SET_W-1:0]      fillSet;
    logic                  fillValid;
    logic [7:0]            fillData;
    logic                  fillReady;
    logic                  fillDone;
    logic                  busy;
    logic                  arrWe;
    logic [SET_W-1:0]      arrSet;
    logic [LINE_BYTES-1:0] arrByteEn;
    logic [7:0]            arrData;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 1'b0;

    // Model: a refill is "in progress" until it has received LINE_BYTES bytes,
    // then reports completion for one cycle.
    bit                    mFilling   = 1'b0;
    bit                    mDonePulse = 1'b0;
    logic [SET_W-1:0]      mFillSet   = '0;
    int                    mCount     = 0;
    logic                  expWe      = 1'b0;
    logic [SET_W-1:0]      expSet     = '0;
    logic [LINE_BYTES-1:0] expBe      = '0;
    logic [7:0]            expData    = '0;

    cache_line_write_ctrl #(.LINE_BYTES(LINE_BYTES), .SETS(SETS)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_st_req      (stReq),
        .i_st_set      (stSet),
        .i_st_byte     (stByte),
        .i_st_data     (stData),
        .o_st_ack      (stAck),
        .i_fill_start  (fillStart),
        .i_fill_set    (fillSet),
        .i_fill_valid  (fillValid),
        .i_fill_data   (fillData),
        .o_fill_ready  (fillReady),
        .o_fill_done   (fillDone),
        .o_busy        (busy),
        .o_arr_we      (arrWe),
        .o_arr_set     (arrSet),
        .o_arr_byte_en (arrByteEn),
        .o_arr_data    (arrData)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic req, input int sSet, input int sByte, input int sData,
                                 input logic start, input int fSet, input logic valid, input int fData);
        stReq     = req;
        stSet     = SET_W'(sSet);
        stByte    = OFF_W'(sByte);
        stData    = 8'(sData);
        fillStart = start;
        fillSet   = SET_W'(fSet);
        fillValid = valid;
        fillData  = 8'(fData);
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit modelAck();
        bit refillByte;
        bit lockHit;
        refillByte = mFilling && fillValid;
        lockHit    = (mFilling && (stSet == mFillSet)) ||
                     (!mFilling && !mDonePulse && fillStart && (stSet == fillSet));
        return !reset && stReq && !refillByte && !lockHit;
    endfunction

    always @(posedge clk) begin
        bit refillByte;
        bit ack;
        if (reset) begin
            mFilling   = 1'b0;
            mDonePulse = 1'b0;
            mCount     = 0;
            expWe      = 1'b0;
            expSet     = '0;
            expBe      = '0;
            expData    = '0;
        end else begin
            refillByte = mFilling && fillValid;
            ack        = modelAck();
            if (refillByte) begin
                expWe   = 1'b1;
                expSet  = mFillSet;
                expBe   = LINE_BYTES'(1 << mCount);
                expData = fillData;
            end else if (ack) begin
                expWe   = 1'b1;
                expSet  = stSet;
                expBe   = LINE_BYTES'(1 << stByte);
                expData = stData;
            end else begin
                expWe = 1'b0;
                expBe = '0;
            end
            if (mDonePulse) begin
                mDonePulse = 1'b0;
            end else if (!mFilling && fillStart) begin
                mFilling = 1'b1;
                mFillSet = fillSet;
                mCount   = 0;
            end else if (refillByte) begin
                mCount++;
                if (mCount == LINE_BYTES) begin
                    mFilling   = 1'b0;
                    mDonePulse = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("mdl st_ack",      32'(stAck),     32'(modelAck()));
            checkOutput("mdl fill_ready",  32'(fillReady), 32'(mFilling));
            checkOutput("mdl fill_done",   32'(fillDone),  32'(mDonePulse));
            checkOutput("mdl busy",        32'(busy),      32'(mFilling || mDonePulse));
            checkOutput("mdl arr_we",      32'(arrWe),     32'(expWe));
            checkOutput("mdl arr_set",     32'(arrSet),    32'(expSet));
            checkOutput("mdl arr_byte_en", 32'(arrByteEn), 32'(expBe));
            checkOutput("mdl arr_data",    32'(arrData),   32'(expData));
        end
    end

    initial begin
        logic [7:0] lineBytes [LINE_BYTES];
        lineBytes[0] = 8'h11;
        lineBytes[1] = 8'h22;
        lineBytes[2] = 8'h33;
        lineBytes[3] = 8'h44;

        // Reset with random inputs
        reset = 1'b1;
        applyStimulus(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                      1'b1, int'($urandom_range(0, 7)), 1'b1, int'($urandom_range(0, 255)));
        nextCycle();
        checkEn = 1'b1;
        applyStimulus(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                      1'b1, int'($urandom_range(0, 7)), 1'b1, int'($urandom_range(0, 255)));
        nextCycle();
        #3;
        checkOutput("rst st_ack",     32'(stAck),     32'd0);
        checkOutput("rst arr_we",     32'(arrWe),     32'd0);
        checkOutput("rst arr_byte_en",32'(arrByteEn), 32'd0);
        checkOutput("rst arr_data",   32'(arrData),   32'd0);
        checkOutput("rst fill_ready", 32'(fillReady), 32'd0);
        reset = 1'b0;
        idleInputs();
        nextCycle();
        checkOutput("rel busy", 32'(busy), 32'd0);

        // IDLE store
        applyStimulus(1'b1, 2, 1, 8'hA5, 1'b0, 0, 1'b0, 0);
        #3;
        checkOutput("idle st_ack", 32'(stAck), 32'd1);
        nextCycle();
        idleInputs();
        #3;
        checkOutput("idle arr_we",      32'(arrWe),     32'd1);
        checkOutput("idle arr_set",     32'(arrSet),    32'd2);
        checkOutput("idle arr_byte_en", 32'(arrByteEn), 32'b0010);
        checkOutput("idle arr_data",    32'(arrData),   32'hA5);
        nextCycle();
        checkOutput("idle arr_we off",  32'(arrWe),     32'd0);

        // Back-to-back refill of set 5
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 5, 1'b0, 0);
        nextCycle();
        checkOutput("fill ready rise", 32'(fillReady), 32'd1);
        for (int i = 0; i < LINE_BYTES; i++) begin
            applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1, int'(lineBytes[i]));
            nextCycle();
            #2;
            checkOutput("b2b arr_we",      32'(arrWe),     32'd1);
            checkOutput("b2b arr_set",     32'(arrSet),    32'd5);
            checkOutput("b2b arr_byte_en", 32'(arrByteEn), 32'(1 << i));
            checkOutput("b2b arr_data",    32'(arrData),   32'(lineBytes[i]));
        end
        checkOutput("b2b fill_done", 32'(fillDone), 32'd1);
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 2, 1'b0, 0);
        nextCycle();
        idleInputs();
        checkOutput("b2b busy low",       32'(busy),      32'd0);
        checkOutput("done start ignored", 32'(fillReady), 32'd0);
        nextCycle();

        // Stores during refill of set 5
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 5, 1'b0, 0);
        nextCycle();
        applyStimulus(1'b1, 3, 0, 8'h33, 1'b0, 0, 1'b1, 8'h50);
        #3;
        checkOutput("prio st_ack", 32'(stAck), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 3, 2, 8'h3C, 1'b0, 0, 1'b0, 0);
        #3;
        checkOutput("gap st_ack", 32'(stAck), 32'd1);
        nextCycle();
        checkOutput("gap arr_set",     32'(arrSet),    32'd3);
        checkOutput("gap arr_byte_en", 32'(arrByteEn), 32'b0100);
        checkOutput("gap arr_data",    32'(arrData),   32'h3C);
        for (int i = 1; i < LINE_BYTES; i++) begin
            applyStimulus(1'b1, 5, 3, 8'h5D, 1'b0, 0, 1'b1, 8'h50 + i);
            #3;
            checkOutput("lock st_ack", 32'(stAck), 32'd0);
            nextCycle();
        end
        applyStimulus(1'b1, 5, 3, 8'h5D, 1'b0, 0, 1'b0, 0);
        #3;
        checkOutput("done fill_done", 32'(fillDone), 32'd1);
        checkOutput("done st_ack",    32'(stAck),    32'd1);
        nextCycle();
        idleInputs();
        checkOutput("done arr_set",     32'(arrSet),    32'd5);
        checkOutput("done arr_byte_en", 32'(arrByteEn), 32'b1000);
        checkOutput("done arr_data",    32'(arrData),   32'h5D);
        nextCycle();

        // fill_start and same-set store together; fill_start during FILL ignored
        applyStimulus(1'b1, 4, 0, 8'h77, 1'b1, 4, 1'b0, 0);
        #3;
        checkOutput("start hit st_ack", 32'(stAck), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 7, 1'b0, 0);
        checkOutput("start hit ready", 32'(fillReady), 32'd1);
        checkOutput("start hit arr_we", 32'(arrWe), 32'd0);
        nextCycle();
        for (int i = 0; i < LINE_BYTES; i++) begin
            applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 8'h40 + i);
            nextCycle();
            checkOutput("relock arr_set", 32'(arrSet), 32'd4);
        end
        idleInputs();
        nextCycle();
        applyStimulus(1'b1, 1, 3, 8'h17, 1'b1, 4, 1'b0, 0);
        #3;
        checkOutput("start miss st_ack", 32'(stAck), 32'd1);
        nextCycle();
        checkOutput("start miss arr_set",     32'(arrSet),    32'd1);
        checkOutput("start miss arr_byte_en", 32'(arrByteEn), 32'b1000);

        // Reset after two refill bytes
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 8'hC0 + i);
            nextCycle();
        end
        reset = 1'b1;
        applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 8'hC2);
        nextCycle();
        checkOutput("midrst arr_we",     32'(arrWe),    32'd0);
        checkOutput("midrst busy",       32'(busy),     32'd0);
        checkOutput("midrst fill_done",  32'(fillDone), 32'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 6, 1'b0, 0);
        nextCycle();
        for (int i = 0; i < LINE_BYTES; i++) begin
            applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 1'b1, 8'h60 + i);
            nextCycle();
            if (i == 0) begin
                checkOutput("restart arr_byte_en", 32'(arrByteEn), 32'b0001);
                checkOutput("restart arr_set",     32'(arrSet),    32'd6);
            end
        end
        idleInputs();
        nextCycle();
        nextCycle();

        checkEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
